// File: rtl/score_display_ctrl.sv
// score_display_ctrl
//   Owns the shared 4-digit seven-segment display. It converts the binary
//   score to BCD with a sequential shift-add-3 engine, multiplexes the four
//   digits from an internal prescaler, and picks what to show. Game-over
//   blink has the highest priority, then the "PAUS" message, then the live
//   score.
//
// Ports
//   clk          system clock
//   rst_n        synchronous active-low reset
//   score        binary score; values above 9999 are clamped to 9999
//   score_valid  single-cycle strobe that samples score
//   paused       level; show "PAUS"
//   gameover     level; blink the score
//   seg          active-low segments {dp, g..a}; dp is always off (1)
//   an           active-low digit enables; an[0] is the rightmost digit
//   busy         a conversion is in progress
module score_display_ctrl #(
  parameter int unsigned SCAN_DIV    = 100000,
  parameter int unsigned BLINK_TICKS = 250
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [14:0] score,
  input  logic        score_valid,
  input  logic        paused,
  input  logic        gameover,
  output logic [7:0]  seg,
  output logic [3:0]  an,
  output logic        busy
);

  localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_COMMIT
  } conv_state_e;

  // ---------------------------------------------------------------------
  // Binary to BCD converter
  // ---------------------------------------------------------------------
  conv_state_e state_q;
  logic [14:0] bin_q;
  logic [15:0] bcd_q;
  logic [3:0]  iter_q;
  logic        busy_q;
  logic        pend_q;
  logic [14:0] pend_val_q;
  logic [15:0] dig_q;       // committed digits {d3, d2, d1, d0}

  logic [15:0] bcd_adj;
  logic [30:0] sh_d;
  logic [15:0] bcd_d;
  logic [14:0] bin_d;

  function automatic logic [14:0] clamp(input logic [14:0] v);
    return (v > 15'd9999) ? 15'd9999 : v;
  endfunction

  // Nibble correction precedes the shift in the same cycle.
  always_comb begin
    bcd_adj = bcd_q;
    for (int unsigned n = 0; n < 4; n++) begin
      if (bcd_q[4*n +: 4] >= 4'd5) begin
        bcd_adj[4*n +: 4] = bcd_q[4*n +: 4] + 4'd3;
      end
    end
    sh_d  = {bcd_adj, bin_q} << 1;
    bcd_d = sh_d[30:15];
    bin_d = sh_d[14:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      iter_q     <= '0;
      busy_q     <= 1'b0;
      pend_q     <= 1'b0;
      pend_val_q <= '0;
      dig_q      <= '0;
    end else begin
      // Any strobe while busy lands in the one-deep pending slot (latest wins).
      if (score_valid && busy_q) begin
        pend_q     <= 1'b1;
        pend_val_q <= score;
      end
      unique case (state_q)
        S_IDLE: begin
          // IDLE with busy still set is the restart edge after a commit
          // that found a pending value.
          if (busy_q) begin
            bin_q   <= clamp(pend_val_q);
            bcd_q   <= '0;
            iter_q  <= '0;
            state_q <= S_SHIFT;
          end else if (score_valid) begin
            bin_q   <= clamp(score);
            bcd_q   <= '0;
            iter_q  <= '0;
            busy_q  <= 1'b1;
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          bcd_q  <= bcd_d;
          bin_q  <= bin_d;
          iter_q <= iter_q + 4'd1;
          if (iter_q == 4'd14) begin
            state_q <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          dig_q   <= bcd_q;
          state_q <= S_IDLE;
          // A strobe in this very cycle has already been written into
          // pend_val_q above; it is consumed by the restart edge.
          if (pend_q || score_valid) begin
            pend_q <= 1'b0;
          end else begin
            busy_q <= 1'b0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Scan scheduler and content selection
  // ---------------------------------------------------------------------
  logic [PW-1:0] presc_q;
  logic [1:0]    idx_q;
  logic [BW-1:0] blink_cnt_q;
  logic          phase_q;
  logic [3:0]    an_q;
  logic [7:0]    seg_q;

  logic          tick;
  logic [1:0]    idx_d;
  logic [3:0]    digit;
  logic          lead_zero;
  logic [3:0]    an_d;
  logic [7:0]    seg_d;
  logic [7:0]    score_seg;
  logic [7:0]    paus_seg;

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  assign tick = (presc_q == PRESC_MAX);

  always_comb begin
    idx_d = idx_q + 2'd1;
    digit = dig_q[{idx_d, 2'b00} +: 4];

    // Blank a digit when it and every digit above it are zero; digit 0 never blanks.
    lead_zero = (idx_d != 2'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      if ((k >= 32'(idx_d)) && (dig_q[4*k +: 4] != 4'd0)) begin
        lead_zero = 1'b0;
      end
    end
    score_seg = lead_zero ? 8'hFF : seg7(digit);

    case (idx_d)
      2'd3:    paus_seg = 8'h8C;
      2'd2:    paus_seg = 8'h88;
      2'd1:    paus_seg = 8'hC1;
      default: paus_seg = 8'h92;
    endcase

    an_d  = ~(4'b0001 << idx_d);
    seg_d = score_seg;
    if (gameover && phase_q) begin
      an_d  = '1;
      seg_d = '1;
    end else if (!gameover && paused) begin
      seg_d = paus_seg;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q     <= '0;
      idx_q       <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      an_q        <= '1;
      seg_q       <= '1;
    end else begin
      presc_q <= tick ? '0 : presc_q + PW'(1);

      if (!gameover) begin
        blink_cnt_q <= '0;
        phase_q     <= 1'b0;
      end else if (tick) begin
        if (blink_cnt_q == BLINK_MAX) begin
          blink_cnt_q <= '0;
          phase_q     <= ~phase_q;
        end else begin
          blink_cnt_q <= blink_cnt_q + BW'(1);
        end
      end

      if (tick) begin
        idx_q <= idx_d;
        an_q  <= an_d;
        seg_q <= seg_d;
      end
    end
  end

  assign seg  = seg_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_score_display_ctrl.sv
module tb_score_display_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] score = '0;
  logic        score_valid = 1'b0;
  logic        paused = 1'b0;
  logic        gameover = 1'b0;
  logic [7:0]  seg;
  logic [3:0]  an;
  logic        busy;

  int passed = 0;
  int total  = 0;
  logic [7:0] rec [4];

  score_display_ctrl #(.SCAN_DIV(4), .BLINK_TICKS(3)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .score      (score),
    .score_valid(score_valid),
    .paused     (paused),
    .gameover   (gameover),
    .seg        (seg),
    .an         (an),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int an_idx(input logic [3:0] a);
    case (a)
      4'b1110: return 0;
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return -1;
    endcase
  endfunction

  // Record the last segment pattern seen on each digit over n cycles.
  task automatic scan(input int n);
    for (int i = 0; i < 4; i++) rec[i] = 8'h00;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (an_idx(an) >= 0) rec[an_idx(an)] = seg;
    end
  endtask

  task automatic chk_digits(input string tag, input logic [7:0] e3, input logic [7:0] e2,
                            input logic [7:0] e1, input logic [7:0] e0);
    chk({tag, " d3"}, rec[3], e3);
    chk({tag, " d2"}, rec[2], e2);
    chk({tag, " d1"}, rec[1], e1);
    chk({tag, " d0"}, rec[0], e0);
  endtask

  task automatic convert(input logic [14:0] v, input string tag);
    int cnt;
    cnt = 0;
    score = v;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    while (busy && cnt < 40) begin
      cnt++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, cnt, 16);
  endtask

  initial begin
    logic [3:0] prev;
    logic [3:0] seqv [4];
    int nchg;
    int found;
    int idx;
    logic busy_ok;
    logic busy33;
    logic saw200;
    logic [7:0] win [4];
    logic [7:0] s42 [4];
    logic [7:0] sp [4];
    logic blank_exp;

    s42[3] = 8'hFF; s42[2] = 8'hFF; s42[1] = 8'h99; s42[0] = 8'hA4;
    sp[3]  = 8'h8C; sp[2]  = 8'h88; sp[1]  = 8'hC1; sp[0]  = 8'h92;

    // Reset
    repeat (3) @(negedge clk);
    chk("reset an", an, 4'hF);
    chk("reset seg", seg, 8'hFF);
    chk("reset busy", busy, 1'b0);
    rst_n = 1'b1;

    // First four ticks: index 1,2,3,0; score 0 shows a single "0"
    prev = an;
    nchg = 0;
    for (int i = 0; i < 4; i++) win[i] = 8'h00;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (an !== prev) begin
        if (nchg < 4) seqv[nchg] = an;
        nchg++;
        prev = an;
      end
      if (an_idx(an) >= 0) win[an_idx(an)] = seg;
    end
    chk("scan changes", nchg, 4);
    chk("scan seq0", seqv[0], 4'b1101);
    chk("scan seq1", seqv[1], 4'b1011);
    chk("scan seq2", seqv[2], 4'b0111);
    chk("scan seq3", seqv[3], 4'b1110);
    chk("post-reset d3", win[3], 8'hFF);
    chk("post-reset d0", win[0], 8'hC0);

    // Test 1: 1234
    convert(15'd1234, "s1234");
    scan(20);
    chk_digits("s1234", 8'hF9, 8'hA4, 8'hB0, 8'h99);

    // Test 2: blanking and clamp
    convert(15'd7, "s7");
    scan(20);
    chk_digits("s7", 8'hFF, 8'hFF, 8'hFF, 8'hF8);
    convert(15'd0, "s0");
    scan(20);
    chk_digits("s0", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    convert(15'd15000, "s15000");
    scan(20);
    chk_digits("s15000", 8'h90, 8'h90, 8'h90, 8'h90);

    // Test 3: strobes at E0 (100), E5 (200), E9 (300)
    busy_ok = 1'b1;
    busy33 = 1'b1;
    saw200 = 1'b0;
    for (int i = 0; i < 4; i++) win[i] = 8'h00;
    for (int e = 0; e <= 35; e++) begin
      score_valid = (e == 0 || e == 5 || e == 9);
      if (e == 0) score = 15'd100;
      if (e == 5) score = 15'd200;
      if (e == 9) score = 15'd300;
      @(negedge clk);
      if (e <= 32 && busy !== 1'b1) busy_ok = 1'b0;
      if (e == 33) busy33 = busy;
      if (an == 4'b1011 && seg == 8'hA4) saw200 = 1'b1;
      if (e >= 17 && e <= 33 && an_idx(an) >= 0) win[an_idx(an)] = seg;
    end
    score_valid = 1'b0;
    chk("pend busy continuous", busy_ok, 1'b1);
    chk("pend busy after E33", busy33, 1'b0);
    chk("pend 100 d3", win[3], 8'hFF);
    chk("pend 100 d2", win[2], 8'hF9);
    chk("pend 100 d1", win[1], 8'hC0);
    chk("pend 100 d0", win[0], 8'hC0);
    scan(20);
    chk_digits("pend 300", 8'hFF, 8'hB0, 8'hC0, 8'hC0);
    chk("pend 200 never shown", saw200, 1'b0);

    // Test 4: paused and gameover blink
    convert(15'd42, "s42");
    paused = 1'b1;
    scan(20);
    chk_digits("paus", 8'h8C, 8'h88, 8'hC1, 8'h92);
    prev = an;
    found = 0;
    for (int c = 0; c < 10 && found == 0; c++) begin
      @(negedge clk);
      if (an !== prev) found = 1;
    end
    chk("blink align", found, 1);
    gameover = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      repeat (4) @(negedge clk);
      blank_exp = (k >= 4 && k <= 6);
      chk($sformatf("blink k%0d blank", k), (an == 4'hF), blank_exp);
      idx = an_idx(an);
      if (!blank_exp && idx >= 0) chk($sformatf("blink k%0d seg", k), seg, s42[idx]);
    end
    gameover = 1'b0;
    repeat (4) @(negedge clk);
    idx = an_idx(an);
    chk("gameover drop an", (idx >= 0), 1'b1);
    if (idx >= 0) chk("gameover drop seg", seg, sp[idx]);

    // Test 5: reset at E8 of a 5678 conversion
    paused = 1'b0;
    score = 15'd5678;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 1'b0);
    chk("abort an", an, 4'hF);
    chk("abort seg", seg, 8'hFF);
    rst_n = 1'b1;
    scan(40);
    chk_digits("abort", 8'hFF, 8'hFF, 8'hFF, 8'hC0);
    chk("abort idle", busy, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
